// File: rtl/cpu_sequencer.sv
// cpu_sequencer: instruction-cycle FSM (FETCH/EXEC1/EXEC2/HALT), post-branch jump flags and retired-instruction counter.
// Optional single-step support is compiled in with `define SEQ_SINGLE_STEP_EN.
module cpu_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             sm_extra_i,
  input  logic             stop_i,
  input  logic             set_jump_i,
  input  logic             ram_wait_i,
  input  logic             step_mode_i,
  input  logic             step_req_i,
  input  logic             cnt_clr_i,
  output logic [1:0]       state_o,
  output logic             jump_o,
  output logic             two_cycles_after_jump_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] instr_count_o
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_EXEC1 = 2'b01,
    ST_EXEC2 = 2'b10,
    ST_HALT  = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic             jump_q, jump_d;
  logic             two_q, two_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic step_mode_s;
  logic step_req_s;
  logic complete_s;
  logic stall_s;
  logic exec_s;

`ifdef SEQ_SINGLE_STEP_EN
  assign step_mode_s = step_mode_i;
  assign step_req_s  = step_req_i;
`else
  logic unused_step_s;
  assign step_mode_s   = 1'b0;
  assign step_req_s    = 1'b0;
  assign unused_step_s = step_mode_i | step_req_i;
`endif

  assign exec_s = (state_q == ST_EXEC1) || (state_q == ST_EXEC2);

  // Next-state decode; stop beats every other request in a running state.
  always_comb begin
    state_d    = state_q;
    complete_s = 1'b0;
    stall_s    = 1'b0;
    case (state_q)
      ST_HALT: begin
        if (start_i || (step_mode_s && step_req_s)) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_HALT;
        end
      end
      ST_FETCH: begin
        if (stop_i) begin
          state_d = ST_HALT;
        end else if (ram_wait_i) begin
          state_d = ST_FETCH;
          stall_s = 1'b1;
        end else begin
          state_d = ST_EXEC1;
        end
      end
      ST_EXEC1: begin
        if (stop_i) begin
          state_d    = ST_HALT;
          complete_s = 1'b1;
        end else if (sm_extra_i) begin
          state_d = ST_EXEC2;
        end else begin
          state_d    = step_mode_s ? ST_HALT : ST_FETCH;
          complete_s = 1'b1;
        end
      end
      ST_EXEC2: begin
        if (stop_i) begin
          state_d    = ST_HALT;
          complete_s = 1'b1;
        end else if (ram_wait_i) begin
          state_d = ST_EXEC2;
          stall_s = 1'b1;
        end else begin
          state_d    = step_mode_s ? ST_HALT : ST_FETCH;
          complete_s = 1'b1;
        end
      end
      default: begin
        state_d = ST_HALT;
      end
    endcase
  end

  // Jump pipeline: frozen by stalls, flushed whenever HALT is next.
  always_comb begin
    jump_d = jump_q;
    two_d  = two_q;
    if (state_d == ST_HALT) begin
      jump_d = 1'b0;
      two_d  = 1'b0;
    end else if (stall_s) begin
      jump_d = jump_q;
      two_d  = two_q;
    end else begin
      jump_d = set_jump_i && exec_s;
      two_d  = jump_q;
    end
  end

  // Retired-instruction counter; clear wins over a coincident completion.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr_i) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (complete_s) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State, jump flags and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_HALT;
      jump_q  <= 1'b0;
      two_q   <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      jump_q  <= jump_d;
      two_q   <= two_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state_o                 = state_q;
  assign jump_o                  = jump_q;
  assign two_cycles_after_jump_o = two_q;
  assign halted_o                = (state_q == ST_HALT);
  assign instr_count_o           = cnt_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed, table-driven bench for cpu_sequencer (counter width 4 to exercise wrap).
module tb_cpu_sequencer;

  localparam logic [1:0] F  = 2'b00;
  localparam logic [1:0] E1 = 2'b01;
  localparam logic [1:0] E2 = 2'b10;
  localparam logic [1:0] H  = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, sm_extra = 1'b0, stop = 1'b0, set_jump = 1'b0;
  logic       ram_wait = 1'b0, step_mode = 1'b0, step_req = 1'b0, cnt_clr = 1'b0;
  logic [1:0] state;
  logic       jump, two, halted;
  logic [3:0] cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [5:0] in;   // {start, sm_extra, stop, set_jump, ram_wait, cnt_clr}
    logic [1:0] st;
    logic       j;
    logic       t;
    logic [3:0] c;
  } vec_t;

  vec_t vecs[$];

  cpu_sequencer #(.CNT_W(4)) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .start_i                 (start),
    .sm_extra_i              (sm_extra),
    .stop_i                  (stop),
    .set_jump_i              (set_jump),
    .ram_wait_i              (ram_wait),
    .step_mode_i             (step_mode),
    .step_req_i              (step_req),
    .cnt_clr_i               (cnt_clr),
    .state_o                 (state),
    .jump_o                  (jump),
    .two_cycles_after_jump_o (two),
    .halted_o                (halted),
    .instr_count_o           (cnt)
  );

  always #5 clk = ~clk;

  function automatic vec_t v(input logic [5:0] in, input logic [1:0] st,
                             input logic j, input logic t, input logic [3:0] c);
    vec_t r;
    r.in = in; r.st = st; r.j = j; r.t = t; r.c = c;
    return r;
  endfunction

  task automatic check(input string name, input logic [1:0] es, input logic ej,
                       input logic et, input logic [3:0] ec);
    logic eh;
    eh = (es == 2'b11);
    checks++;
    if (state !== es || halted !== eh || jump !== ej || two !== et || cnt !== ec) begin
      errors++;
      $display("FAIL %s: got state=%b halted=%b jump=%b two=%b cnt=%0d, want state=%b halted=%b jump=%b two=%b cnt=%0d",
               name, state, halted, jump, two, cnt, es, eh, ej, et, ec);
    end
  endtask

  task automatic step(input logic [5:0] in);
    {start, sm_extra, stop, set_jump, ram_wait, cnt_clr} = in;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Expected outputs after the edge that samples each input set.
    vecs.push_back(v(6'b100000, F,  1'b0, 1'b0, 4'd0));
    vecs.push_back(v(6'b000000, E1, 1'b0, 1'b0, 4'd0));
    vecs.push_back(v(6'b000000, F,  1'b0, 1'b0, 4'd1));
    vecs.push_back(v(6'b000000, E1, 1'b0, 1'b0, 4'd1));
    vecs.push_back(v(6'b000000, F,  1'b0, 1'b0, 4'd2));
    vecs.push_back(v(6'b000000, E1, 1'b0, 1'b0, 4'd2));
    vecs.push_back(v(6'b010000, E2, 1'b0, 1'b0, 4'd2));
    vecs.push_back(v(6'b000010, E2, 1'b0, 1'b0, 4'd2));
    vecs.push_back(v(6'b000010, E2, 1'b0, 1'b0, 4'd2));
    vecs.push_back(v(6'b000000, F,  1'b0, 1'b0, 4'd3));
    vecs.push_back(v(6'b000000, E1, 1'b0, 1'b0, 4'd3));
    vecs.push_back(v(6'b000100, F,  1'b1, 1'b0, 4'd4));
    vecs.push_back(v(6'b000010, F,  1'b1, 1'b0, 4'd4));
    vecs.push_back(v(6'b000000, E1, 1'b0, 1'b1, 4'd4));
    vecs.push_back(v(6'b010100, E2, 1'b1, 1'b0, 4'd4));
    vecs.push_back(v(6'b000010, E2, 1'b1, 1'b0, 4'd4));
    vecs.push_back(v(6'b000000, F,  1'b0, 1'b1, 4'd5));
    vecs.push_back(v(6'b000000, E1, 1'b0, 1'b0, 4'd5));
    vecs.push_back(v(6'b111100, H,  1'b0, 1'b0, 4'd6));
    vecs.push_back(v(6'b000000, H,  1'b0, 1'b0, 4'd6));
    vecs.push_back(v(6'b100100, F,  1'b0, 1'b0, 4'd6));
    vecs.push_back(v(6'b001100, H,  1'b0, 1'b0, 4'd6));
    vecs.push_back(v(6'b100000, F,  1'b0, 1'b0, 4'd6));
    vecs.push_back(v(6'b100000, E1, 1'b0, 1'b0, 4'd6));
    vecs.push_back(v(6'b100000, F,  1'b0, 1'b0, 4'd7));
    vecs.push_back(v(6'b000001, E1, 1'b0, 1'b0, 4'd0));
    vecs.push_back(v(6'b000000, F,  1'b0, 1'b0, 4'd1));
    vecs.push_back(v(6'b000000, E1, 1'b0, 1'b0, 4'd1));
    vecs.push_back(v(6'b000001, F,  1'b0, 1'b0, 4'd0));
    vecs.push_back(v(6'b000000, E1, 1'b0, 1'b0, 4'd0));
    vecs.push_back(v(6'b010000, E2, 1'b0, 1'b0, 4'd0));
    vecs.push_back(v(6'b001010, H,  1'b0, 1'b0, 4'd1));

    #12;
    check("reset", H, 1'b0, 1'b0, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_after_reset", H, 1'b0, 1'b0, 4'd0);

    foreach (vecs[i]) begin
      step(vecs[i].in);
      check($sformatf("vec%0d", i), vecs[i].st, vecs[i].j, vecs[i].t, vecs[i].c);
    end

    // Wrap: clear, 15 completions to preload all-ones, one more wraps to 0.
    step(6'b100001);
    check("wrap_start", F, 1'b0, 1'b0, 4'd0);
    for (int i = 1; i <= 16; i++) begin
      logic [3:0] ec;
      ec = 4'(i);
      step(6'b000000);
      check($sformatf("wrap_e1_%0d", i), E1, 1'b0, 1'b0, 4'(i - 1));
      step(6'b000000);
      check($sformatf("wrap_f_%0d", i), F, 1'b0, 1'b0, ec);
    end
    step(6'b000000);
    step(6'b000000);
    check("pre_clr", F, 1'b0, 1'b0, 4'd1);
    step(6'b000000);
    step(6'b000001);
    check("clr_vs_complete", F, 1'b0, 1'b0, 4'd0);

    // Asynchronous reset in the middle of EXEC2 with a live jump flag.
    step(6'b000000);
    step(6'b010100);
    check("pre_async_rst", E2, 1'b1, 1'b0, 4'd0);
    step(6'b000010);
    check("pre_async_rst2", E2, 1'b1, 1'b0, 4'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", H, 1'b0, 1'b0, 4'd0);
    {start, sm_extra, stop, set_jump, ram_wait, cnt_clr} = 6'b000000;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

`ifdef SEQ_SINGLE_STEP_EN
    step_req = 1'b1;
    step(6'b000000);
    step_req = 1'b0;
    check("step_req_no_mode", H, 1'b0, 1'b0, 4'd0);
    step_mode = 1'b1;
    for (int p = 0; p < 2; p++) begin
      logic [3:0] ec;
      ec = 4'(p + 1);
      step_req = 1'b1;
      step(6'b000000);
      step_req = 1'b0;
      check($sformatf("step%0d_fetch", p), F, 1'b0, 1'b0, 4'(p));
      step(6'b000000);
      check($sformatf("step%0d_exec1", p), E1, 1'b0, 1'b0, 4'(p));
      step(6'b000000);
      check($sformatf("step%0d_halt", p), H, 1'b0, 1'b0, ec);
      step(6'b000000);
      step(6'b000000);
      check($sformatf("step%0d_idle", p), H, 1'b0, 1'b0, ec);
    end
    step_mode = 1'b0;
`else
    step_mode = 1'b1;
    step_req  = 1'b1;
    step(6'b000000);
    step_req  = 1'b0;
    check("step_ignored", H, 1'b0, 1'b0, 4'd0);
    step(6'b100000);
    check("nostep_fetch", F, 1'b0, 1'b0, 4'd0);
    step(6'b000000);
    check("nostep_exec1", E1, 1'b0, 1'b0, 4'd0);
    step(6'b000000);
    check("nostep_complete_fetch", F, 1'b0, 1'b0, 4'd1);
    step_mode = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Owns the CPU's instruction-cycle state machine. Generates the `state[1:0]` code consumed by the instruction decoder (fetch / exec1 / exec2) and stretches instructions to three cycles when the decoder requests it. Also halts on `stop`, stalls on RAM wait, and produces the post-branch flags `jump` and `two_cycles_after_jump`. Sits between the decoder and the PC / RAM blocks, and keeps a retired-instruction counter for debug.

## Interface

Parameters:
- `CNT_W`, 16: width of the retired-instruction counter.

Ports:
- `clk` input 1: single clock, all state on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: pulse; leaves HALT into free run.
- `sm_extra` input 1: from decoder; in EXEC1, requests an EXEC2 cycle.
- `stop` input 1: from decoder; stp or stack overflow, go to HALT.
- `set_jump` input 1: from decoder; the current cycle redirects the PC.
- `ram_wait` input 1: RAM not ready; freezes FETCH and EXEC2.
- `step_mode` input 1: single-step enable (see Configuration).
- `step_req` input 1: pulse; runs exactly one instruction from HALT.
- `cnt_clr` input 1: synchronous clear of `instr_count`.
- `state` output 2: 00 FETCH, 01 EXEC1, 10 EXEC2, 11 HALT.
- `jump` output 1: cycle immediately after a `set_jump` cycle.
- `two_cycles_after_jump` output 1: second cycle after a `set_jump` cycle.
- `halted` output 1: equals (state == HALT).
- `instr_count` output CNT_W: instructions completed, wraps.

## Operation

- HALT is encoded 11 so the decoder's fetch, exec1 and exec2 terms are all 0. With every control strobe off, the PC and RAM are inert.
- Transitions are evaluated each rising edge. Priority is listed top-down.
  - Any running state with `stop`=1 goes to HALT. This overrides `ram_wait` and `sm_extra`.
  - HALT: `start` or (`step_mode` and `step_req`) goes to FETCH. Otherwise stay.
  - FETCH: `ram_wait` stays in FETCH. Otherwise go to EXEC1.
  - EXEC1: `sm_extra` goes to EXEC2. Otherwise the instruction completes.
  - EXEC2: `ram_wait` stays in EXEC2. Otherwise the instruction completes.
- On completion, the next state is HALT if `step_mode`, otherwise FETCH.
- A stop taken in EXEC1 or EXEC2 counts as a completion. A stop taken in FETCH does not.
- `instr_count` increments by 1 on each completion and wraps from all-ones to 0.
  - `cnt_clr` has priority over the increment.
  - `cnt_clr` works in any state.
- Jump pipeline:
  - `jump` is registered from `set_jump`, taken only when state is EXEC1 or EXEC2.
  - `two_cycles_after_jump` is registered from `jump`.
  - Both stages hold while a stall freezes the state (FETCH or EXEC2 with `ram_wait`).
  - Both stages clear on entry to HALT.
- `start` or `step_req` while running: ignored. They are not queued.

## Timing

- Reset values:
  - `state`=11 (HALT), `halted`=1.
  - `jump`=0, `two_cycles_after_jump`=0.
  - `instr_count`=0.
- Reset mid-instruction aborts immediately and returns all outputs to their reset values. No completion is counted.
- `start` high in cycle N gives FETCH in cycle N+1.
- Instruction length with no wait is 2 cycles normally, or 3 cycles with `sm_extra`. Each `ram_wait` cycle adds 1.
- `set_jump` in cycle N:
  - `jump`=1 in cycle N+1.
  - `two_cycles_after_jump`=1 in cycle N+2.
  - Stalls stretch these points.
- `stop` and `start` in the same EXEC1 cycle: stop wins. HALT is entered and `start` is lost.
- All outputs are registered except `halted`, which is decoded from the state register. There are no combinational input-to-output paths.

## Configuration

- `SEQ_SINGLE_STEP_EN` defined:
  - `step_mode` and `step_req` behave as described above.
- Not defined:
  - `step_mode` and `step_req` are ignored internally and treated as 0.
  - Completion always goes to FETCH.
  - HALT is left only on `start`.
  - Both ports remain present; tie them low.

## Test plan

- Reset, then `start` pulse, then a 2-cycle instruction stream with no `sm_extra`:
  - `state` sequence 11,00,01,00,01.
  - `instr_count` reaches 2 after two EXEC1 cycles.
- `sm_extra`=1 in EXEC1, then `ram_wait`=1 for 2 cycles in EXEC2:
  - `state` sequence 01,10,10,10,00.
  - `instr_count` increments once, on the last edge.
- `set_jump`=1 in EXEC1 at cycle 5, with `ram_wait`=1 in the following FETCH:
  - `jump`=1 in cycles 6–7.
  - `two_cycles_after_jump`=1 in cycle 8.
- `stop` asserted in EXEC1 together with `sm_extra` and `start`:
  - Next `state`=11, `halted`=1, `jump`=0, `instr_count`+1.
  - `start` is ignored.
- With `SEQ_SINGLE_STEP_EN`, `step_mode`=1, two `step_req` pulses 5 cycles apart:
  - Each pulse gives exactly 00,01, then 11.
  - `instr_count` goes 0→1→2.
- Counter wrap at `CNT_W`=4: preload via 15 completions, then one more gives `instr_count`=0.
  - `cnt_clr` coincident with a completion leaves `instr_count`=0.
  - `rst_n` low mid-EXEC2 gives `state`=11 asynchronously.
